// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared types, legality constants and helpers for the io_arb
//            bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

  // Bus sequencer phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int c_NCH_MIN  = 1;
  localparam int c_NCH_MAX  = 8;
  localparam int c_WAIT_MAX = 15;
  // Data-phase counter width; it saturates, so an unbounded rdy stretch is safe
  localparam int c_CNT_W    = 16;

  // Width of a channel index; a single channel still needs one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Parameter legality for the sequencer
  function automatic bit params_ok(input int nch, input int dw, input int aw,
                                   input int wt, input int tmo);
    return (aw > dw) && (nch >= c_NCH_MIN) && (nch <= c_NCH_MAX) &&
           (wt >= 0) && (wt <= c_WAIT_MAX) &&
           (tmo >= 0) && (tmo < (1 << c_CNT_W));
  endfunction

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : io_arb_if
// Purpose  : Requester channels plus multiplexed external bus of io_arb.
//            master = sequencer side, slave = requesters / external bus side.
// Revision : 1.0 - initial release
// ============================================================================
interface io_arb_if #(
  parameter int NCH = 2,
  parameter int DW  = 16,
  parameter int AW  = 20
);
  // Requester side
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    rw;
  logic [NCH*AW-1:0] adr;
  logic [NCH*DW-1:0] dtw;
  logic [DW-1:0]     dtr;
  logic [NCH-1:0]    ack;
  logic              err;
  logic              busy;
  // External bus side
  logic [DW-1:0]     din;
  logic [DW-1:0]     dout;
  logic [AW-DW-1:0]  adr_hi;
  logic              ale;
  logic              oe;
  logic              we;
  logic              isout;
  logic              rdy;

  modport master (
    input  req, rw, adr, dtw, din, rdy,
    output dtr, ack, err, busy, dout, adr_hi, ale, oe, we, isout
  );

  modport slave (
    output req, rw, adr, dtw, din, rdy,
    input  dtr, ack, err, busy, dout, adr_hi, ale, oe, we, isout
  );
endinterface : io_arb_if
`default_nettype wire

// File: rtl/io_arb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : Combinational request arbiter. RR=1 searches upward from the
//            pointer with wrap-around; RR=0 gives the highest index priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb
  import io_pkg::*;
#(
  parameter int NCH = 2,
  parameter int RR  = 1,
  localparam int c_IW = idx_w(NCH)
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [c_IW-1:0] i_ptr,
  output logic [NCH-1:0]  o_gnt,
  output logic [c_IW-1:0] o_idx
);

  logic            w_found;
  logic [c_IW-1:0] w_ch;

  // First requesting channel in search order wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_ch    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (RR != 0) begin
        w_ch = c_IW'((int'(i_ptr) + k) % NCH);
      end else begin
        w_ch = c_IW'(NCH - 1 - k);
      end
      if (!w_found && i_req[w_ch]) begin
        w_found      = 1'b1;
        o_gnt[w_ch]  = 1'b1;
        o_idx        = w_ch;
      end
    end
  end

endmodule : rr_arb
`default_nettype wire

// File: rtl/io_arb.sv
`default_nettype none
// ============================================================================
// Module   : io_arb
// Purpose  : Multi-channel bus sequencer. Arbitrates requesters, then runs an
//            address phase and one read/write data phase on the external bus
//            with wait states, rdy stretching and an optional timeout.
// Revision : 1.0 - initial release
// ============================================================================
module io_arb
  import io_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DW   = 16,
  parameter int AW   = 20,
  parameter int WAIT = 0,
  parameter int RR   = 1,
  parameter int TMO  = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  io_arb_if.master bus
);

  localparam int c_IW = idx_w(NCH);
  localparam logic [c_CNT_W-1:0] c_WAIT_CNT = c_CNT_W'(WAIT);
  // Counter value seen in the last data-phase cycle allowed before timeout
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = (TMO > 0) ? c_CNT_W'(TMO - 1) : '0;

  if (!params_ok(NCH, DW, AW, WAIT, TMO)) begin : g_param_check
    $error("io_arb: illegal parameters (need AW > DW, 1 <= NCH <= 8, 0 <= WAIT <= 15)");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_IW-1:0]    r_ptr;
  logic [NCH-1:0]     r_gnt;
  logic               r_rw;
  logic [AW-1:0]      r_adr;
  logic [DW-1:0]      r_dtw;
  logic [DW-1:0]      r_dtr;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;

  logic [NCH-1:0]     w_gnt;
  logic [c_IW-1:0]    w_idx;
  logic [c_IW-1:0]    w_ptr_nxt;
  logic               w_any;
  logic               w_min_done;
  logic               w_rdy_exit;
  logic               w_tmo_hit;
  logic               w_data_exit;

  rr_arb #(
    .NCH (NCH),
    .RR  (RR)
  ) u_rr_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_any       = |bus.req;
  assign w_min_done  = (r_cnt >= c_WAIT_CNT);
  assign w_rdy_exit  = w_min_done && bus.rdy;
  // A normal rdy exit in the same cycle as the timeout takes precedence
  assign w_tmo_hit   = (TMO > 0) && (r_cnt >= c_TMO_LAST);
  assign w_data_exit = w_rdy_exit || w_tmo_hit;
  assign w_ptr_nxt   = (w_idx == c_IW'(NCH - 1)) ? '0 : w_idx + 1'b1;
  assign bus.dtr     = r_dtr;

  // State register; async reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus outputs decoded from the current phase
  always_comb begin
    w_state_nxt = r_state;
    bus.ale     = 1'b0;
    bus.oe      = 1'b0;
    bus.we      = 1'b0;
    bus.isout   = 1'b0;
    bus.busy    = 1'b0;
    bus.dout    = '0;
    bus.adr_hi  = '0;
    bus.ack     = '0;
    bus.err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        bus.ale     = 1'b1;
        bus.isout   = 1'b1;
        bus.busy    = 1'b1;
        bus.dout    = r_adr[DW-1:0];
        bus.adr_hi  = r_adr[AW-1:DW];
        w_state_nxt = DATA;
      end
      DATA: begin
        bus.busy = 1'b1;
        if (r_rw) begin
          bus.isout = 1'b1;
          bus.we    = 1'b1;
          bus.dout  = r_dtw;
        end else begin
          bus.oe = 1'b1;
        end
        if (w_data_exit) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy    = 1'b1;
        bus.ack     = r_gnt;
        bus.err     = r_err;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant capture, data-phase counting and read-data/error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_gnt <= '0;
      r_rw  <= 1'b0;
      r_adr <= '0;
      r_dtw <= '0;
      r_dtr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt <= w_gnt;
            r_rw  <= bus.rw[w_idx];
            r_adr <= bus.adr[w_idx*AW +: AW];
            r_dtw <= bus.dtw[w_idx*DW +: DW];
            r_cnt <= '0;
            r_err <= 1'b0;
            if (RR != 0) begin
              r_ptr <= w_ptr_nxt;
            end
          end
        end
        DATA: begin
          if (w_rdy_exit) begin
            if (!r_rw) begin
              r_dtr <= bus.din;
            end
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : io_arb
`default_nettype wire

// File: tb/tb_io_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_arb
// Purpose  : Self-checking bench for io_arb: table-driven single transactions
//            plus directed wait-state, rdy-stretch, timeout, arbitration and
//            reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_arb;

  logic clk = 1'b0;
  logic rst_n;
  logic rst0_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  io_arb_if #(.NCH(2), .DW(16), .AW(20)) if0 ();
  io_arb_if #(.NCH(2), .DW(16), .AW(20)) if1 ();
  io_arb_if #(.NCH(3), .DW(16), .AW(20)) if2 ();
  io_arb_if #(.NCH(3), .DW(16), .AW(20)) if3 ();

  io_arb #(.NCH(2), .DW(16), .AW(20), .WAIT(0), .RR(1), .TMO(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(if0.master));
  io_arb #(.NCH(2), .DW(16), .AW(20), .WAIT(2), .RR(1), .TMO(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));
  io_arb #(.NCH(3), .DW(16), .AW(20), .WAIT(0), .RR(1), .TMO(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master));
  io_arb #(.NCH(3), .DW(16), .AW(20), .WAIT(0), .RR(0), .TMO(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.master));

  // Round-robin and fixed-priority instances see identical stimulus
  assign if3.req = if2.req;
  assign if3.rw  = if2.rw;
  assign if3.adr = if2.adr;
  assign if3.dtw = if2.dtw;
  assign if3.din = if2.din;
  assign if3.rdy = if2.rdy;

  typedef struct {
    int          ch;
    logic        rw;
    logic [19:0] adr;
    logic [15:0] dtw;
    logic [15:0] din;
    logic [15:0] e_lo;
    logic [3:0]  e_hi;
    logic [15:0] e_dat;
    logic [1:0]  e_ack;
    logic [15:0] e_dtr;
  } vec_t;

  vec_t tbl [5];
  vec_t post_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One minimum-length transaction on the WAIT=0 instance
  task automatic run_u0(input vec_t v);
    if0.req                  = 2'(1 << v.ch);
    if0.rw[v.ch]             = v.rw;
    if0.adr[v.ch*20 +: 20]   = v.adr;
    if0.dtw[v.ch*16 +: 16]   = v.dtw;
    if0.din                  = v.din;
    if0.rdy                  = 1'b1;
    tick();
    chk("u0_addr_ale",   32'(if0.ale),    32'(1'b1));
    chk("u0_addr_lo",    32'(if0.dout),   32'(v.e_lo));
    chk("u0_addr_hi",    32'(if0.adr_hi), 32'(v.e_hi));
    chk("u0_addr_isout", 32'(if0.isout),  32'(1'b1));
    chk("u0_addr_busy",  32'(if0.busy),   32'(1'b1));
    tick();
    chk("u0_data_ale",   32'(if0.ale),    32'(1'b0));
    chk("u0_data_oe",    32'(if0.oe),     32'(!v.rw));
    chk("u0_data_we",    32'(if0.we),     32'(v.rw));
    chk("u0_data_isout", 32'(if0.isout),  32'(v.rw));
    chk("u0_data_dout",  32'(if0.dout),   32'(v.e_dat));
    tick();
    chk("u0_done_ack",   32'(if0.ack),    32'(v.e_ack));
    chk("u0_done_err",   32'(if0.err),    32'(1'b0));
    chk("u0_done_dtr",   32'(if0.dtr),    32'(v.e_dtr));
    chk("u0_done_strb",  32'({if0.ale, if0.oe, if0.we, if0.isout}), 32'(4'b0000));
    if0.req = 2'b00;
    tick();
    chk("u0_idle_ack",   32'(if0.ack),    32'(2'b00));
    chk("u0_idle_busy",  32'(if0.busy),   32'(1'b0));
  endtask

  logic [2:0] exp_rr [4];

  initial begin
    tbl[0] = '{0, 1'b0, 20'hA1234, 16'h0000, 16'hBEEF, 16'h1234, 4'hA, 16'h0000, 2'b01, 16'hBEEF};
    tbl[1] = '{1, 1'b1, 20'h00010, 16'h5A5A, 16'h1111, 16'h0010, 4'h0, 16'h5A5A, 2'b10, 16'hBEEF};
    tbl[2] = '{1, 1'b0, 20'hFFFFF, 16'h0000, 16'h0001, 16'hFFFF, 4'hF, 16'h0000, 2'b10, 16'h0001};
    tbl[3] = '{0, 1'b1, 20'h5C3A7, 16'hFFFF, 16'hDEAD, 16'hC3A7, 4'h5, 16'hFFFF, 2'b01, 16'h0001};
    tbl[4] = '{0, 1'b0, 20'h00000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 2'b01, 16'h0000};
    post_rst = '{1, 1'b0, 20'h12345, 16'h0000, 16'h4321, 16'h2345, 4'h1, 16'h0000, 2'b10, 16'h4321};
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};

    rst_n  = 1'b0;
    rst0_n = 1'b0;
    if0.req = '0; if0.rw = '0; if0.adr = '0; if0.dtw = '0; if0.din = '0; if0.rdy = 1'b1;
    if1.req = '0; if1.rw = '0; if1.adr = '0; if1.dtw = '0; if1.din = '0; if1.rdy = 1'b1;
    if2.req = '0; if2.rw = '0; if2.adr = '0; if2.dtw = '0; if2.din = '0; if2.rdy = 1'b1;
    tick();
    tick();
    // Reset values
    chk("rst_outs",  32'({if0.ale, if0.oe, if0.we, if0.isout, if0.busy, if0.err}), 32'(6'b0));
    chk("rst_dout",  32'(if0.dout),   32'(16'h0000));
    chk("rst_adrhi", 32'(if0.adr_hi), 32'(4'h0));
    chk("rst_ack",   32'(if0.ack),    32'(2'b00));
    chk("rst_dtr",   32'(if0.dtr),    32'(16'h0000));
    rst_n  = 1'b1;
    rst0_n = 1'b1;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 5; i++) begin
      run_u0(tbl[i]);
    end

    // rdy low for 5 sampled edges: DATA lasts 6 cycles
    if0.req = 2'b01; if0.rw[0] = 1'b0; if0.adr[19:0] = 20'h00042;
    if0.din = 16'h7777; if0.rdy = 1'b0;
    tick();
    chk("stretch_ale", 32'(if0.ale), 32'(1'b1));
    for (int d = 1; d <= 6; d++) begin
      tick();
      chk("stretch_oe",  32'(if0.oe),  32'(1'b1));
      chk("stretch_ack", 32'(if0.ack), 32'(2'b00));
      if (d == 6) if0.rdy = 1'b1;
    end
    tick();
    chk("stretch_ack_done", 32'(if0.ack), 32'(2'b01));
    chk("stretch_err",      32'(if0.err), 32'(1'b0));
    chk("stretch_dtr",      32'(if0.dtr), 32'(16'h7777));
    if0.req = 2'b00;
    tick();

    // Async reset in the middle of a read data phase
    if0.req = 2'b10; if0.rw[1] = 1'b0; if0.adr[39:20] = 20'h12345; if0.din = 16'h4321;
    tick();
    tick();
    chk("rst_mid_pre_oe", 32'(if0.oe), 32'(1'b1));
    #2 rst0_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({if0.ale, if0.oe, if0.we, if0.isout, if0.busy, if0.err}), 32'(6'b0));
    chk("rst_mid_ack",  32'(if0.ack),  32'(2'b00));
    chk("rst_mid_dout", 32'(if0.dout), 32'(16'h0000));
    chk("rst_mid_dtr",  32'(if0.dtr),  32'(16'h0000));
    if0.req = 2'b00;
    tick();
    tick();
    rst0_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_mid_noack", 32'({if0.ack, if0.busy}), 32'(3'b000));
    end
    run_u0(post_rst);

    // WAIT=2 write on channel 1
    if1.req = 2'b10; if1.rw = 2'b10; if1.adr[39:20] = 20'h00010; if1.dtw[31:16] = 16'h5A5A;
    if1.rdy = 1'b1;
    tick();
    chk("w2_addr", 32'({if1.ale, if1.isout, if1.dout}), 32'({1'b1, 1'b1, 16'h0010}));
    for (int d = 1; d <= 3; d++) begin
      tick();
      chk("w2_data", 32'({if1.we, if1.isout, if1.oe, if1.dout}), 32'({1'b1, 1'b1, 1'b0, 16'h5A5A}));
      chk("w2_data_ack", 32'(if1.ack), 32'(2'b00));
    end
    tick();
    chk("w2_done_ack",   32'(if1.ack), 32'(2'b10));
    chk("w2_done_strb",  32'({if1.we, if1.isout}), 32'(2'b00));
    if1.req = 2'b00;
    tick();

    // WAIT=2 read to load dtr, then a timed-out read that must leave it alone
    if1.req = 2'b01; if1.rw = 2'b00; if1.adr[19:0] = 20'h0ABCD; if1.din = 16'hABCD;
    tick();
    for (int d = 1; d <= 3; d++) begin
      tick();
      chk("rd2_oe", 32'(if1.oe), 32'(1'b1));
    end
    tick();
    chk("rd2_ack", 32'({if1.ack, if1.err, if1.dtr}), 32'({2'b01, 1'b0, 16'hABCD}));
    if1.req = 2'b00;
    tick();
    if1.req = 2'b01; if1.din = 16'h9999; if1.rdy = 1'b0;
    tick();
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("tmo_oe",  32'(if1.oe),  32'(1'b1));
      chk("tmo_ack", 32'(if1.ack), 32'(2'b00));
    end
    tick();
    chk("tmo_done_ack", 32'(if1.ack), 32'(2'b01));
    chk("tmo_done_err", 32'(if1.err), 32'(1'b1));
    chk("tmo_done_dtr", 32'(if1.dtr), 32'(16'hABCD));
    if1.req = 2'b00;
    tick();
    chk("tmo_after", 32'({if1.err, if1.ack, if1.busy}), 32'(4'b0000));

    // All three channels held: round-robin rotates, fixed priority sticks at 2
    if2.req = 3'b111; if2.rw = 3'b000; if2.adr = {20'h30003, 20'h20002, 20'h10001};
    if2.rdy = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (s % 4 == 3) begin
        chk("rr_ack",  32'(if2.ack), 32'(exp_rr[s/4]));
        chk("fix_ack", 32'(if3.ack), 32'(3'b100));
      end else if (s % 4 == 0) begin
        chk("b2b_idle", 32'({if2.busy, if3.busy}), 32'(2'b00));
      end else begin
        chk("b2b_noack", 32'({if2.ack, if3.ack}), 32'(6'b0));
      end
    end
    if2.req = 3'b000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_io_arb
`default_nettype wire

// File: doc/io_arb.md
# io_arb

Parametrised multi-channel bus sequencer between CPU-side requesters (instruction queue, execution engine, DMA) and the multiplexed external address/data bus. It arbitrates among `NCH` request/acknowledge channels with fixed or round-robin priority and runs one address phase followed by one read or write data phase. Data phases support programmable wait states, an external `rdy` stretch and an optional timeout. Read data is registered, so requesters no longer depend on `din` staying stable.

## Interface
Parameters:
- `NCH`, 2, number of requester channels (1..8)
- `DW`, 16, data width
- `AW`, 20, address width; must be > `DW`
- `WAIT`, 0, fixed extra data-phase cycles (0..15)
- `RR`, 1, 1 = round-robin priority, 0 = fixed priority (highest index wins)
- `TMO`, 0, timeout in data-phase cycles; 0 disables

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  NCH  per-channel request
- `rw`  in  NCH  per-channel direction, 1 = write
- `adr`  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
- `dtw`  in  NCH*DW  per-channel write data
- `dtr`  out  DW  registered read data, shared
- `ack`  out  NCH  one-cycle completion pulse to the granted channel
- `err`  out  1  one-cycle pulse with `ack` when the transaction timed out
- `busy`  out  1  high from ADDR through DONE
- `din`  in  DW  external bus input
- `dout`  out  DW  external bus output (address low, then write data)
- `adr_hi`  out  AW-DW  upper address bits
- `ale`, `oe`, `we`  out  1 each  address latch, read strobe, write strobe
- `isout`  out  1  bus output enable
- `rdy`  in  1  external ready; low stretches the data phase

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, wait/timeout counters 0.
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if any `req` is high, compute the grant and latch channel g, its `rw`, `adr` and `dtw`, then go to ADDR. Otherwise stay in IDLE.
- ADDR: `ale`=1, `isout`=1, `busy`=1, `{adr_hi,dout}`=latched address. Always go to DATA.
- DATA, read: `ale`=0, `isout`=0, `oe`=1.
- DATA, write: `ale`=0, `isout`=1, `we`=1, `dout`=latched `dtw`.
- DATA exit: DATA lasts `WAIT`+1 cycles minimum, then remains until `rdy`=1 is sampled.
  - On exit from a read, `dtr` <= `din` at the same clock edge.
  - If `TMO`≠0 and the phase reaches `TMO` cycles, exit anyway. Set the error flag; `dtr` is left unchanged.
- DONE: strobes 0, `isout`=0, `ack[g]`=1 and `err`=flag for exactly one cycle. Then go to IDLE.
- Round-robin: after a grant, the pointer moves to g+1 mod NCH. The search starts at the pointer and wraps. With `RR`=0 the pointer is unused.
- Requester rule: hold `req`, `rw`, `adr` and `dtw` stable until `ack`. Drop `req` on the edge that samples `ack`, or it is served again.
- A `req` that drops mid-transaction is ignored; the transaction completes and `ack` still pulses.
- `dtr` holds its value until the next completed read.
- Async reset mid-transaction: outputs go to reset values immediately, no `ack` is issued, and the pending transaction is lost.

## Timing
- Minimum transaction is 4 cycles: IDLE(grant), ADDR, DATA, DONE.
- With continuous requests, back-to-back transactions take 4 cycles each, with `busy` low for one cycle (IDLE) between them.
- Latency from `req` rising to `ack` = 3 + `WAIT` + (cycles `rdy` is low after the minimum phase).
- `dtr` is valid in the `ack` cycle and afterwards.
- `ale`, `oe` and `we` are full-cycle registered strobes; they are never high together.

## Structure
- Package `io_pkg`: state enum (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, DONE=2'd3) and width/parameter legality constants.
- Sub-module `rr_arb` (params `NCH`, `RR`): inputs `req` and pointer; output one-hot grant plus index; combinational.
- Elaboration-time check: `AW` > `DW`, 1 ≤ `NCH` ≤ 8.

## Test plan
- Single read, ch0, adr=20'hA1234, din=16'hBEEF, `WAIT`=0, `rdy`=1 -> `ale` with dout=16'h1234 and adr_hi=4'hA, then `oe` for 1 cycle, `ack[0]` at cycle 3, dtr=16'hBEEF.
- Write, ch1, adr=20'h0_0010, dtw=16'h5A5A, `WAIT`=2 -> `we` high for 3 cycles with dout=16'h5A5A, `isout` high for ADDR+DATA, `ack[1]` at cycle 5.
- `NCH`=3, `RR`=1, all `req` held -> grants in order 0,1,2,0. With `RR`=0 -> always channel 2.
- `rdy` held low 5 cycles in DATA, `TMO`=0 -> DATA lasts 6 cycles, then `ack`, `err`=0.
- `TMO`=4, `rdy` stuck low -> exit after 4 DATA cycles, `ack` with `err`=1, `dtr` unchanged.
- `rst_n` asserted during DATA -> all outputs 0 immediately, no `ack`; after release, a new request completes normally.
